// File: rtl/rx_hold_buffer.sv
// Frame-aware XGMII RX hold buffer: stores 64-bit words plus 8-bit status and
// exposes only committed frames; overflowing, truncated or malformed frames are rewound.
module rx_hold_buffer #(
    parameter int AWIDTH              = 4,
    parameter int ALMOST_FULL_THRESH  = 4,
    parameter int ALMOST_EMPTY_THRESH = 7
) (
    input  logic        clk_xgmii_rx,
    input  logic        reset_xgmii_rx,
    input  logic [63:0] rxhfifo_wdata,
    input  logic [7:0]  rxhfifo_wstatus,
    input  logic        rxhfifo_wen,
    input  logic        rxhfifo_ren,
    output logic [63:0] rxhfifo_rdata,
    output logic [7:0]  rxhfifo_rstatus,
    output logic        rxhfifo_rvalid,
    output logic        rxhfifo_rempty,
    output logic        rxhfifo_ralmost_empty,
    output logic        rxhfifo_wfull,
    output logic        rxhfifo_walmost_full,
    output logic        rxhfifo_drop_pulse,
    output logic [15:0] rxhfifo_drop_count
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_P = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] PTR_ONE = (AWIDTH + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   cmt_ptr_q, cmt_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [7:0]        rstatus_q, rstatus_d;
    logic              rvalid_q, rvalid_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic [71:0]       mem_q [DEPTH];

    logic              sop, eop;
    logic              rempty, full_w, rd_en;
    logic [AWIDTH:0]   used, committed, free_words;
    logic              mem_we, start_frame;
    logic [AWIDTH:0]   base;
    logic [AWIDTH-1:0] wr_addr;
    logic [1:0]        drop_n;
    logic [16:0]       count_sum;

    assign sop = rxhfifo_wstatus[7];
    assign eop = rxhfifo_wstatus[6];

    assign used       = wr_ptr_q - rd_ptr_q;
    assign committed  = cmt_ptr_q - rd_ptr_q;
    assign free_words = DEPTH_P - used;
    assign full_w     = (used == DEPTH_P);
    assign rempty     = (cmt_ptr_q == rd_ptr_q);

    // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        mem_we      = 1'b0;
        drop_n      = 2'd0;
        start_frame = 1'b0;
        base        = wr_ptr_q;
        wr_addr     = wr_ptr_q[AWIDTH-1:0];

        if (rxhfifo_wen) begin
            case (state_q)
                S_IDLE: start_frame = 1'b1;
                S_FRAME: begin
                    if (sop) begin
                        // Truncated frame: rewind, then treat this word as a fresh start.
                        wr_ptr_d    = cmt_ptr_q;
                        drop_n      = 2'd1;
                        base        = cmt_ptr_q;
                        start_frame = 1'b1;
                    end else if (full_w) begin
                        wr_ptr_d = cmt_ptr_q;
                        drop_n   = 2'd1;
                        state_d  = eop ? S_IDLE : S_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (eop) begin
                            cmt_ptr_d = wr_ptr_q + PTR_ONE;
                            state_d   = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (sop) begin
                        start_frame = 1'b1;
                    end else if (eop) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (start_frame) begin
            state_d = S_IDLE;
            wr_addr = base[AWIDTH-1:0];
            if (sop) begin
                if ((base - rd_ptr_q) == DEPTH_P) begin
                    drop_n = drop_n + 2'd1;
                    if (!eop) begin
                        state_d = S_DROP;
                    end
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = base + PTR_ONE;
                    if (eop) begin
                        cmt_ptr_d = base + PTR_ONE;
                    end else begin
                        state_d = S_FRAME;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_en        = rxhfifo_ren & ~rempty;
        rd_ptr_d     = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rdata_d      = rd_en ? mem_q[rd_ptr_q[AWIDTH-1:0]][63:0]  : rdata_q;
        rstatus_d    = rd_en ? mem_q[rd_ptr_q[AWIDTH-1:0]][71:64] : rstatus_q;
        rvalid_d     = rd_en;
        drop_pulse_d = (drop_n != 2'd0);
        count_sum    = {1'b0, drop_count_q} + 17'(drop_n);
        drop_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_xgmii_rx) begin
        if (reset_xgmii_rx) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            cmt_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            rdata_q      <= '0;
            rstatus_q    <= '0;
            rvalid_q     <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cmt_ptr_q    <= cmt_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rdata_q      <= rdata_d;
            rstatus_q    <= rstatus_d;
            rvalid_q     <= rvalid_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: storage is not reset; pointers alone decide which entries are meaningful.
    always_ff @(posedge clk_xgmii_rx) begin
        if (mem_we) begin
            mem_q[wr_addr] <= {rxhfifo_wstatus, rxhfifo_wdata};
        end
    end

    assign rxhfifo_rdata         = rdata_q;
    assign rxhfifo_rstatus       = rstatus_q;
    assign rxhfifo_rvalid        = rvalid_q;
    assign rxhfifo_rempty        = rempty;
    assign rxhfifo_ralmost_empty = (32'(committed) <= ALMOST_EMPTY_THRESH);
    assign rxhfifo_wfull         = full_w;
    assign rxhfifo_walmost_full  = (32'(free_words) <= ALMOST_FULL_THRESH);
    assign rxhfifo_drop_pulse    = drop_pulse_q;
    assign rxhfifo_drop_count    = drop_count_q;

endmodule

// File: tb/tb_rx_hold_buffer.sv
// Self-checking bench for rx_hold_buffer: directed frame scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_rx_hold_buffer;

    localparam int DEPTH = 16;
    localparam int AF    = 4;
    localparam int AE    = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] wdata;
    logic [7:0]  wstatus;
    logic        wen, ren;
    logic [63:0] rdata;
    logic [7:0]  rstatus;
    logic        rvalid, rempty, ralmost_empty, wfull, walmost_full, drop_pulse;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    rx_hold_buffer #(
        .AWIDTH(4),
        .ALMOST_FULL_THRESH(AF),
        .ALMOST_EMPTY_THRESH(AE)
    ) dut (
        .clk_xgmii_rx(clk),
        .reset_xgmii_rx(rst),
        .rxhfifo_wdata(wdata),
        .rxhfifo_wstatus(wstatus),
        .rxhfifo_wen(wen),
        .rxhfifo_ren(ren),
        .rxhfifo_rdata(rdata),
        .rxhfifo_rstatus(rstatus),
        .rxhfifo_rvalid(rvalid),
        .rxhfifo_rempty(rempty),
        .rxhfifo_ralmost_empty(ralmost_empty),
        .rxhfifo_wfull(wfull),
        .rxhfifo_walmost_full(walmost_full),
        .rxhfifo_drop_pulse(drop_pulse),
        .rxhfifo_drop_count(drop_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: committed words readable by the reader, pending words of the open frame.
    typedef enum int {M_IDLE, M_FRAME, M_DROP} mode_t;
    mode_t       mode;
    logic [71:0] cq[$];
    logic [71:0] pq[$];
    logic [63:0] e_rdata;
    logic [7:0]  e_rstatus;
    bit          e_rvalid, e_pulse;
    int          e_count;
    int          m_drops;

    task automatic model_reset();
        cq.delete();
        pq.delete();
        mode      = M_IDLE;
        e_rdata   = '0;
        e_rstatus = '0;
        e_rvalid  = 0;
        e_pulse   = 0;
        e_count   = 0;
    endtask

    task automatic model_commit();
        while (pq.size() > 0) cq.push_back(pq.pop_front());
    endtask

    task automatic model_start(input bit sop, input bit eop, input logic [71:0] w);
        mode = M_IDLE;
        if (!sop) return;
        if (cq.size() + pq.size() == DEPTH) begin
            m_drops++;
            if (!eop) mode = M_DROP;
        end else begin
            pq.push_back(w);
            if (eop) model_commit();
            else mode = M_FRAME;
        end
    endtask

    task automatic model_step(input bit w_en, input logic [7:0] st, input logic [63:0] d, input bit r_en);
        bit          sop, eop, rd_ok;
        logic [71:0] w, r;
        sop     = st[7];
        eop     = st[6];
        w       = {st, d};
        rd_ok   = r_en && (cq.size() != 0);
        m_drops = 0;
        if (w_en) begin
            case (mode)
                M_IDLE: model_start(sop, eop, w);
                M_FRAME: begin
                    if (sop) begin
                        pq.delete();
                        m_drops++;
                        model_start(sop, eop, w);
                    end else if (cq.size() + pq.size() == DEPTH) begin
                        pq.delete();
                        m_drops++;
                        mode = eop ? M_IDLE : M_DROP;
                    end else begin
                        pq.push_back(w);
                        if (eop) begin
                            model_commit();
                            mode = M_IDLE;
                        end
                    end
                end
                M_DROP: begin
                    if (sop) model_start(sop, eop, w);
                    else if (eop) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
        end
        if (rd_ok) begin
            r         = cq.pop_front();
            e_rdata   = r[63:0];
            e_rstatus = r[71:64];
            e_rvalid  = 1;
        end else begin
            e_rvalid = 0;
        end
        e_pulse = (m_drops > 0);
        e_count = (e_count + m_drops > 65535) ? 65535 : e_count + m_drops;
    endtask

    task automatic check_outputs();
        int used;
        used = cq.size() + pq.size();
        check("rvalid", rvalid, e_rvalid);
        check("rdata", rdata, e_rdata);
        check("rstatus", rstatus, e_rstatus);
        check("rempty", rempty, cq.size() == 0);
        check("ralmost_empty", ralmost_empty, cq.size() <= AE);
        check("wfull", wfull, used == DEPTH);
        check("walmost_full", walmost_full, (DEPTH - used) <= AF);
        check("drop_pulse", drop_pulse, e_pulse);
        check("drop_count", drop_count, e_count);
    endtask

    task automatic step(input bit w_en, input logic [7:0] st, input logic [63:0] d, input bit r_en);
        rst     = 1'b0;
        wen     = w_en;
        wstatus = st;
        wdata   = d;
        ren     = r_en;
        @(posedge clk);
        model_step(w_en, st, d, r_en);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input bit r_en);
        rst = 1'b1;
        wen = 1'b0;
        ren = r_en;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    int          gen_left, gen_len, ren_pct;
    logic [7:0]  st;
    bit          w_en;

    initial begin
        rst     = 1'b1;
        wen     = 1'b0;
        ren     = 1'b0;
        wdata   = '0;
        wstatus = '0;
        model_reset();

        // Reset state
        do_reset(0);
        check("reset_rempty", rempty, 1'b1);

        // 3-word frame, then read it back
        step(1, 8'h80, 64'h1111_0000_0000_0001, 0);
        step(1, 8'h00, 64'h1111_0000_0000_0002, 0);
        step(1, 8'h45, 64'h1111_0000_0000_0003, 0);
        check("tp3_committed", rempty, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 64'h0, 1);
        check("tp3_last_word", rdata, 64'h1111_0000_0000_0003);

        // Single-word frame
        step(1, 8'hC3, 64'h2222_0000_0000_00C3, 0);
        step(0, 8'h00, 64'h0, 1);
        check("single_rstatus", rstatus, 8'hC3);
        step(0, 8'h00, 64'h0, 1);

        // 20-word frame overflow with no reads
        for (int i = 0; i < 20; i++) begin
            st = (i == 0) ? 8'h80 : (i == 19) ? 8'h40 : 8'h00;
            step(1, st, rnd64(), 0);
        end
        check("ovf_drop_count", drop_count, 16'd1);
        check("ovf_rempty", rempty, 1'b1);
        step(1, 8'h80, 64'h3333_0000_0000_0001, 0);
        step(1, 8'h40, 64'h3333_0000_0000_0002, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 64'h0, 1);

        // Truncated frame followed by a good 2-word frame
        step(1, 8'h80, 64'h4444_0000_0000_0001, 0);
        step(1, 8'h00, 64'h4444_0000_0000_0002, 0);
        step(1, 8'h80, 64'h5555_0000_0000_0001, 0);
        step(1, 8'h40, 64'h5555_0000_0000_0002, 0);
        check("trunc_drop_count", drop_count, 16'd2);
        step(0, 8'h00, 64'h0, 1);
        check("trunc_first_read", rdata, 64'h5555_0000_0000_0001);
        for (int i = 0; i < 2; i++) step(0, 8'h00, 64'h0, 1);

        // Stray words in IDLE are silently discarded
        step(1, 8'h00, rnd64(), 0);
        step(1, 8'h40, rnd64(), 0);
        check("stray_drop_count", drop_count, 16'd2);
        check("stray_rempty", rempty, 1'b1);

        // Reset mid-read discards committed data
        step(1, 8'h80, rnd64(), 0);
        step(1, 8'h00, rnd64(), 0);
        step(1, 8'h00, rnd64(), 0);
        step(1, 8'h40, rnd64(), 0);
        step(0, 8'h00, 64'h0, 1);
        do_reset(1);
        check("rst_rvalid", rvalid, 1'b0);
        step(0, 8'h00, 64'h0, 1);
        check("rst_ren_rvalid", rvalid, 1'b0);

        // Random traffic with varying reader speed
        gen_left = 0;
        gen_len  = 0;
        for (int phase = 0; phase < 8; phase++) begin
            case (phase % 4)
                0: ren_pct = 0;
                1: ren_pct = 30;
                2: ren_pct = 70;
                default: ren_pct = 100;
            endcase
            for (int c = 0; c < 500; c++) begin
                w_en = ($urandom_range(0, 3) != 0);
                st   = 8'h00;
                if (w_en) begin
                    if (gen_left == 0 && $urandom_range(0, 15) == 0) begin
                        st = {2'b00, 6'($urandom)};
                    end else begin
                        if (gen_left == 0) begin
                            gen_len  = $urandom_range(1, 22);
                            gen_left = gen_len;
                        end
                        st[7]   = (gen_left == gen_len);
                        st[6]   = (gen_left == 1);
                        st[5:0] = 6'($urandom);
                        gen_left--;
                        if (gen_left > 0 && $urandom_range(0, 19) == 0) gen_left = 0;
                    end
                end
                step(w_en, st, rnd64(), $urandom_range(0, 99) < ren_pct);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
